// File: rtl/alu_pkg.sv
// Shared constants for the 4-bit ALU and its result FIFO.
// ALU_RESULT_FLAGS_EN adds per-entry zero/carry flags to the stored entry.
package alu_pkg;

  localparam int ALU_DATA_W = 4;
  localparam int ALU_OP_W   = 4;

  // Opcode map, 4'b0000..4'b1111
  localparam logic [3:0] OP_OR_RED   = 4'b0000;
  localparam logic [3:0] OP_AND_RED  = 4'b0001;
  localparam logic [3:0] OP_XOR_RED  = 4'b0010;
  localparam logic [3:0] OP_NOR_RED  = 4'b0011;
  localparam logic [3:0] OP_NAND_RED = 4'b0100;
  localparam logic [3:0] OP_XNOR_RED = 4'b0101;
  localparam logic [3:0] OP_OR       = 4'b0110;
  localparam logic [3:0] OP_AND      = 4'b0111;
  localparam logic [3:0] OP_XOR      = 4'b1000;
  localparam logic [3:0] OP_SUB      = 4'b1001;
  localparam logic [3:0] OP_ADD      = 4'b1010;
  localparam logic [3:0] OP_INC      = 4'b1011;
  localparam logic [3:0] OP_MUL      = 4'b1100;
  localparam logic [3:0] OP_SHL      = 4'b1101;
  localparam logic [3:0] OP_SHR      = 4'b1110;
  localparam logic [3:0] OP_NOT      = 4'b1111;

  // Extra bits carried per entry when flags are stored alongside the data
`ifdef ALU_RESULT_FLAGS_EN
  localparam int FLAG_W = 2;
`else
  localparam int FLAG_W = 0;
`endif

  localparam int ALU_ENTRY_W = 2 * ALU_DATA_W + ALU_OP_W + FLAG_W;

  function automatic int entry_w(input int data_w, input int op_w);
    return 2 * data_w + op_w + FLAG_W;
  endfunction

endpackage

// File: rtl/alu_fifo_mem.sv
// FIFO storage: DEPTH x W register array, one synchronous write port,
// one asynchronous read port (gives first-word-fall-through at the top).
module alu_fifo_mem #(
  parameter int DEPTH = 4,
  parameter int W     = 12
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);

  logic [W-1:0] mem_q [DEPTH];

  // Write the pushed entry; contents are not reset, occupancy tracks validity
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/alu_result_fifo.sv
// ALU result FIFO: queues {op,y,x} with valid/ready on both sides and counts
// results offered while full (saturating). Optional ALU_RESULT_FLAGS_EN adds
// out_zero/out_carry, computed at push time and stored with the entry.
module alu_result_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = ALU_DATA_W,
  parameter int OP_W   = ALU_OP_W,
  parameter int DROP_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_x,
  input  logic [DATA_W-1:0]        in_y,
  input  logic [OP_W-1:0]          in_op,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_x,
  output logic [DATA_W-1:0]        out_y,
  output logic [OP_W-1:0]          out_op,
`ifdef ALU_RESULT_FLAGS_EN
  output logic                     out_zero,
  output logic                     out_carry,
`endif
  output logic [$clog2(DEPTH):0]   count,
  output logic [DROP_W-1:0]        drop_cnt
);

  localparam int AW      = $clog2(DEPTH);
  localparam int ENTRY_W = entry_w(DATA_W, OP_W);

  logic [AW:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DROP_W-1:0]   drop_q, drop_d;
  logic                full, empty, push, pop;
  logic [ENTRY_W-1:0]  wr_entry, rd_entry, head;

  // Pointers carry a wrap bit: equal -> empty, differ only in wrap bit -> full
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // No pass-through when full: a pop that cycle does not free a slot early
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

`ifdef ALU_RESULT_FLAGS_EN
  logic zero_flag, carry_flag;
  assign zero_flag  = ({in_y, in_x} == '0);
  assign carry_flag = (in_op == OP_W'(OP_ADD)) ? in_y[0] : 1'b0;
  assign wr_entry   = {zero_flag, carry_flag, in_op, in_y, in_x};
`else
  assign wr_entry   = {in_op, in_y, in_x};
`endif

  alu_fifo_mem #(.DEPTH(DEPTH), .W(ENTRY_W)) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata (wr_entry),
    .raddr (rd_ptr_q[AW-1:0]),
    .rdata (rd_entry)
  );

  // Stale storage is never exposed: head reads as zero while empty
  assign head = empty ? '0 : rd_entry;
  assign out_x  = head[DATA_W-1:0];
  assign out_y  = head[2*DATA_W-1:DATA_W];
  assign out_op = head[2*DATA_W+OP_W-1:2*DATA_W];
`ifdef ALU_RESULT_FLAGS_EN
  assign out_carry = head[2*DATA_W+OP_W];
  assign out_zero  = head[2*DATA_W+OP_W+1];
`endif

  assign count    = wr_ptr_q - rd_ptr_q;
  assign drop_cnt = drop_q;

  // Next-state: advance pointers on handshakes, count rejected offers with saturation
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    drop_d   = drop_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (in_valid && full && !(&drop_q)) drop_d = drop_q + 1'b1;
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      drop_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      drop_q   <= drop_d;
    end
  end

endmodule

// File: tb/tb_alu_result_fifo.sv
// Directed self-checking bench for alu_result_fifo (DEPTH=4, DATA_W=4, OP_W=4, DROP_W=8).
// Build with ALU_RESULT_FLAGS_EN to also exercise the zero/carry flags.
module tb_alu_result_fifo;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst, in_valid, out_ready;
  logic       in_ready, out_valid;
  logic [3:0] in_x, in_y, in_op, out_x, out_y, out_op;
  logic [2:0] count;
  logic [7:0] drop_cnt;
`ifdef ALU_RESULT_FLAGS_EN
  logic       out_zero, out_carry;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_result_fifo #(.DEPTH(4), .DATA_W(4), .OP_W(4), .DROP_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_y      (in_y),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_x     (out_x),
    .out_y     (out_y),
    .out_op    (out_op),
`ifdef ALU_RESULT_FLAGS_EN
    .out_zero  (out_zero),
    .out_carry (out_carry),
`endif
    .count     (count),
    .drop_cnt  (drop_cnt)
  );

  // Advance one clock; everything after returns 1 time unit past the edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_x = '0; in_y = '0; in_op = '0;
    cyc(); cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (drop_cnt !== 8'd0) begin failures++; $display("FAIL reset_drop got=%0d exp=0", drop_cnt); end
    checks++; if ({out_op, out_y, out_x} !== 12'h000) begin failures++; $display("FAIL reset_outs got=%h exp=000", {out_op, out_y, out_x}); end
  endtask

  task automatic test_single();
    in_valid = 1'b1; in_x = 4'h5; in_y = 4'h0; in_op = 4'b1011;
    cyc();
    in_valid = 1'b0; in_x = 4'hF; in_op = 4'h0;   // changes after push must not matter
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", out_valid); end
    checks++; if ({out_op, out_y, out_x} !== 12'hB05) begin failures++; $display("FAIL single_data got=%h exp=B05", {out_op, out_y, out_x}); end
    checks++; if (count !== 3'd1) begin failures++; $display("FAIL single_count got=%0d exp=1", count); end
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_pop_valid got=%b exp=0", out_valid); end
    checks++; if (out_x !== 4'h0) begin failures++; $display("FAIL single_empty_x got=%h exp=0", out_x); end
  endtask

  task automatic test_overflow();
    out_ready = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      in_valid = 1'b1; in_x = 4'(i); in_y = 4'(i + 8); in_op = OP_OR;
      cyc();
    end
    in_valid = 1'b0;
    checks++; if (count !== 3'd4) begin failures++; $display("FAIL ovf_count got=%0d exp=4", count); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL ovf_in_ready got=%b exp=0", in_ready); end
    checks++; if (drop_cnt !== 8'd2) begin failures++; $display("FAIL ovf_drop got=%0d exp=2", drop_cnt); end
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_x !== 4'(i) || out_y !== 4'(i + 8)) begin
        failures++; $display("FAIL ovf_drain%0d got=v%b x%h y%h exp=v1 x%h y%h", i, out_valid, out_x, out_y, 4'(i), 4'(i + 8));
      end
      cyc();
    end
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL ovf_empty got=%b exp=0", out_valid); end
  endtask

  task automatic test_full_simul();
    for (int i = 8; i <= 11; i++) begin
      in_valid = 1'b1; in_x = 4'(i); in_y = 4'h0; in_op = OP_AND;
      cyc();
    end
    // Full: offer and pop together -> pop only, offer dropped
    in_valid = 1'b1; in_x = 4'hC; out_ready = 1'b1;
    cyc();
    checks++; if (count !== 3'd3) begin failures++; $display("FAIL fs_count got=%0d exp=3", count); end
    checks++; if (drop_cnt !== 8'd3) begin failures++; $display("FAIL fs_drop got=%0d exp=3", drop_cnt); end
    checks++; if (out_x !== 4'h9) begin failures++; $display("FAIL fs_head got=%h exp=9", out_x); end
    in_valid = 1'b1; in_x = 4'hD; out_ready = 1'b0;
    cyc();
    in_valid = 1'b0;
    checks++; if (count !== 3'd4 || drop_cnt !== 8'd3) begin failures++; $display("FAIL fs_push got=c%0d d%0d exp=c4 d3", count, drop_cnt); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic [3:0] exp_x;
      exp_x = (i == 3) ? 4'hD : 4'(9 + i);
      checks++; if (out_x !== exp_x) begin failures++; $display("FAIL fs_drain%0d got=%h exp=%h", i, out_x, exp_x); end
      cyc();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_x = 4'(i); in_y = ~4'(i); in_op = OP_XOR;
      if (i > 0) begin
        checks++;
        if (count !== 3'd1 || out_x !== 4'(i - 1) || out_y !== ~4'(i - 1)) begin
          failures++; $display("FAIL b2b%0d got=c%0d x%h y%h exp=c1 x%h y%h", i, count, out_x, out_y, 4'(i - 1), ~4'(i - 1));
        end
      end
      cyc();
    end
    in_valid = 1'b0;
    checks++; if (out_x !== 4'(19) || count !== 3'd1) begin failures++; $display("FAIL b2b_last got=c%0d x%h exp=c1 x3", count, out_x); end
    cyc();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || drop_cnt !== 8'd0) begin failures++; $display("FAIL b2b_end got=v%b d%0d exp=v0 d0", out_valid, drop_cnt); end
  endtask

  task automatic test_drop_sat();
    out_ready = 1'b0; in_valid = 1'b1; in_x = 4'h1;
    for (int i = 0; i < 4 + 260; i++) cyc();
    in_valid = 1'b0;
    checks++; if (drop_cnt !== 8'hFF) begin failures++; $display("FAIL drop_sat got=%0d exp=255", drop_cnt); end
    checks++; if (count !== 3'd4) begin failures++; $display("FAIL drop_sat_count got=%0d exp=4", count); end
  endtask

  task automatic test_flags_and_reset();
    do_reset();
    in_valid = 1'b1; in_op = OP_ADD; in_y = 4'h1; in_x = 4'h0;
    cyc();
    in_op = OP_MUL; in_y = 4'h0; in_x = 4'h0;
    cyc();
    in_op = OP_ADD; in_y = 4'h2; in_x = 4'h3;
    cyc();
    in_valid = 1'b0;
    checks++; if (count !== 3'd3) begin failures++; $display("FAIL rst3_count_pre got=%0d exp=3", count); end
`ifdef ALU_RESULT_FLAGS_EN
    checks++; if (out_carry !== 1'b1 || out_zero !== 1'b0) begin failures++; $display("FAIL flags_add got=z%b c%b exp=z0 c1", out_zero, out_carry); end
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    checks++; if (out_zero !== 1'b1 || out_carry !== 1'b0) begin failures++; $display("FAIL flags_mul got=z%b c%b exp=z1 c0", out_zero, out_carry); end
    in_valid = 1'b1; in_op = OP_SUB; in_y = 4'h0; in_x = 4'h0;
    cyc();
    in_valid = 1'b0;
`endif
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin failures++; $display("FAIL rst_mid got=c%0d v%b exp=c0 v0", count, out_valid); end
    checks++; if ({out_op, out_y, out_x} !== 12'h000 || in_ready !== 1'b1) begin failures++; $display("FAIL rst_mid_outs got=%h r%b exp=000 r1", {out_op, out_y, out_x}, in_ready); end
`ifdef ALU_RESULT_FLAGS_EN
    checks++; if (out_zero !== 1'b0 || out_carry !== 1'b0) begin failures++; $display("FAIL rst_flags got=z%b c%b exp=z0 c0", out_zero, out_carry); end
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_full_simul();
    test_back_to_back();
    test_drop_sat();
    test_flags_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
